multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// The controller owns the master modport; the datapath side owns the slave modport.
interface multicycle_ctrl_if;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 4;

    logic [INSTR_W-1:0] Instr;
    logic [FLAG_W-1:0]  ALUFlags;
    logic               MemReady;

    logic [1:0]         RegSrc;
    logic [1:0]         ImmSrc;
    logic [ALUC_W-1:0]  ALUControl;
    logic               RegWrite;
    logic               ALUSrc;
    logic               MemToReg;
    logic               PCSrc;
    logic               MemWrite;
    logic               PCWrite;
    logic               IRWrite;
    logic               InstrDone;
    logic [STATE_W-1:0] State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output RegSrc, ImmSrc, ALUControl, RegWrite, ALUSrc, MemToReg, PCSrc,
               MemWrite, PCWrite, IRWrite, InstrDone, State
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  RegSrc, ImmSrc, ALUControl, RegWrite, ALUSrc, MemToReg, PCSrc,
               MemWrite, PCWrite, IRWrite, InstrDone, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: sequences fetch/decode/execute/memory/writeback,
// evaluates condition codes against a private flag register and drives datapath selects.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    // Instruction fields
    logic [3:0]          cond;
    logic [1:0]          op;
    logic [5:0]          funct;
    logic [3:0]          cmd;
    logic [3:0]          rd;
    logic                up_bit;
    logic                unused_instr;

    assign cond   = bus.Instr[31:28];
    assign op     = bus.Instr[27:26];
    assign funct  = bus.Instr[25:20];
    assign cmd    = funct[4:1];
    assign rd     = bus.Instr[15:12];
    assign up_bit = bus.Instr[23];
    // Link bit and register/immediate fields are consumed by the datapath only.
    assign unused_instr = ^{bus.Instr[24], bus.Instr[19:16], bus.Instr[11:0]};

    // Output drivers (combinational by design)
    logic [1:0]          reg_src_c;
    logic [1:0]          imm_src_c;
    logic [ALUC_W-1:0]   alu_control_c;
    logic                reg_write_c;
    logic                alu_src_c;
    logic                mem_to_reg_c;
    logic                pc_src_c;
    logic                mem_write_c;
    logic                pc_write_c;
    logic                ir_write_c;
    logic                instr_done_c;

    // Data-processing command decode: ALU select, register write and flag write qualifiers
    logic [ALUC_W-1:0]   dp_alu_c;
    logic                dp_writes_c;
    logic                dp_is_cmp_c;
    logic                dp_ok_c;
    logic                dp_flags_c;

    always_comb begin
        dp_alu_c    = 4'b0000;
        dp_writes_c = 1'b0;
        dp_is_cmp_c = 1'b0;
        dp_ok_c     = 1'b1;
        case (cmd)
            4'b0100: begin dp_alu_c = 4'b0000; dp_writes_c = 1'b1; end
            4'b0010: begin dp_alu_c = 4'b0001; dp_writes_c = 1'b1; end
            4'b0000: begin dp_alu_c = 4'b0010; dp_writes_c = 1'b1; end
            4'b1100: begin dp_alu_c = 4'b0011; dp_writes_c = 1'b1; end
            4'b0001: begin dp_alu_c = 4'b0100; dp_writes_c = 1'b1; end
            4'b1101: begin dp_alu_c = 4'b0101; dp_writes_c = 1'b1; end
            4'b1010: begin dp_alu_c = 4'b0001; dp_is_cmp_c = 1'b1; end
            default: begin dp_alu_c = 4'b0000; dp_ok_c     = 1'b0; end
        endcase
        // Unsupported commands never touch the flags, even with S set.
        dp_flags_c = dp_is_cmp_c | (funct[0] & dp_ok_c);
    end

    // Condition evaluation against the stored {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex_c;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_ex_c = 1'b0;
        case (cond)
            4'b0000: cond_ex_c = flag_z;
            4'b0001: cond_ex_c = ~flag_z;
            4'b0010: cond_ex_c = flag_c;
            4'b0011: cond_ex_c = ~flag_c;
            4'b0100: cond_ex_c = flag_n;
            4'b0101: cond_ex_c = ~flag_n;
            4'b0110: cond_ex_c = flag_v;
            4'b0111: cond_ex_c = ~flag_v;
            4'b1000: cond_ex_c = flag_c & ~flag_z;
            4'b1001: cond_ex_c = ~flag_c | flag_z;
            4'b1010: cond_ex_c = (flag_n == flag_v);
            4'b1011: cond_ex_c = (flag_n != flag_v);
            4'b1100: cond_ex_c = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex_c = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex_c = 1'b1;
            default: cond_ex_c = 1'b0;
        endcase
    end

    // State and flag registers; reset wins over any wait state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        reg_src_c     = 2'b00;
        imm_src_c     = 2'b00;
        alu_control_c = 4'b0000;
        reg_write_c   = 1'b0;
        alu_src_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        pc_src_c      = 1'b0;
        mem_write_c   = 1'b0;
        pc_write_c    = 1'b0;
        ir_write_c    = 1'b0;
        instr_done_c  = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write_c = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                if (!cond_ex_c || op == 2'b11) begin
                    pc_write_c   = 1'b1;
                    instr_done_c = 1'b1;
                    state_d      = FETCH;
                end else begin
                    case (op)
                        2'b00:   state_d = funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                alu_src_c     = funct[5];
                alu_control_c = dp_alu_c;
                state_d       = ALUWB;
            end
            ALUWB: begin
                reg_write_c  = dp_writes_c;
                pc_src_c     = dp_writes_c && (rd == 4'hF);
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                if (dp_flags_c) begin
                    flags_d = bus.ALUFlags;
                end
                state_d      = FETCH;
            end
            MEMADR, MEMRD: begin
                // Address computation stays on the bus for the whole read wait.
                alu_src_c     = 1'b1;
                imm_src_c     = 2'b01;
                alu_control_c = up_bit ? 4'b0000 : 4'b0001;
                reg_src_c     = funct[0] ? 2'b00 : 2'b10;
                if (state_q == MEMADR) begin
                    state_d = funct[0] ? MEMRD : MEMWR;
                end else if (bus.MemReady) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                pc_src_c     = (rd == 4'hF);
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                mem_write_c = 1'b1;
                if (bus.MemReady) begin
                    pc_write_c   = 1'b1;
                    instr_done_c = 1'b1;
                    state_d      = FETCH;
                end
            end
            BRANCH: begin
                reg_src_c    = 2'b01;
                imm_src_c    = 2'b10;
                alu_src_c    = 1'b1;
                pc_src_c     = 1'b1;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Architectural side effects are suppressed while reset is held.
        if (reset) begin
            reg_write_c  = 1'b0;
            mem_write_c  = 1'b0;
            pc_write_c   = 1'b0;
            ir_write_c   = 1'b0;
            instr_done_c = 1'b0;
        end
    end

    // Drive the bus
    assign bus.RegSrc     = reg_src_c;
    assign bus.ImmSrc     = imm_src_c;
    assign bus.ALUControl = alu_control_c;
    assign bus.RegWrite   = reg_write_c;
    assign bus.ALUSrc     = alu_src_c;
    assign bus.MemToReg   = mem_to_reg_c;
    assign bus.PCSrc      = pc_src_c;
    assign bus.MemWrite   = mem_write_c;
    assign bus.PCWrite    = pc_write_c;
    assign bus.IRWrite    = ir_write_c;
    assign bus.InstrDone  = instr_done_c;
    assign bus.State      = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by random
// instructions, each checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;
    localparam int C_SKIP = 0;
    localparam int C_DP   = 1;
    localparam int C_BR   = 2;
    localparam int C_LDR  = 3;
    localparam int C_STR  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] model_flags = 4'b0000;
    logic [3:0] flag_in     = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Condition codes: pairs share a base predicate, odd codes invert it (1111 -> never).
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        bit base;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit cmd_supported(input logic [3:0] cmd);
        return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010};
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'b0000;
            4'b0010: return 4'b0001;
            4'b0000: return 4'b0010;
            4'b1100: return 4'b0011;
            4'b0001: return 4'b0100;
            4'b1101: return 4'b0101;
            4'b1010: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] observed_ctl();
        return {bus.RegSrc, bus.ImmSrc, bus.ALUControl, bus.RegWrite, bus.ALUSrc,
                bus.MemToReg, bus.PCSrc, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.InstrDone};
    endfunction

    // Run one instruction from its FETCH cycle to its last cycle, checking every cycle.
    // Entered and left just after a rising edge with the DUT expected in FETCH.
    task automatic run_instr(input string name, input logic [31:0] ins, input int w);
        logic [1:0] op     = ins[27:26];
        logic       imm    = ins[25];
        logic [3:0] cmd    = ins[24:21];
        logic       sbit   = ins[20];
        logic       up     = ins[23];
        logic [3:0] rd     = ins[15:12];
        bit         writes = cmd_supported(cmd) && (cmd != 4'b1010);
        bit         loads  = (cmd == 4'b1010) || (sbit && cmd_supported(cmd));
        int         cls;
        int         lat;
        if (!cond_holds(ins[31:28], model_flags) || op == 2'b11) cls = C_SKIP;
        else if (op == 2'b00)                                     cls = C_DP;
        else if (op == 2'b01)                                     cls = sbit ? C_LDR : C_STR;
        else                                                      cls = C_BR;
        case (cls)
            C_SKIP:  lat = 2;
            C_DP:    lat = 4;
            C_BR:    lat = 3;
            C_LDR:   lat = 5 + w;
            default: lat = 4 + w;
        endcase
        bus.Instr = ins;
        for (int k = 0; k < lat; k++) begin
            logic [3:0] e_state = 4'(k);
            logic [1:0] e_rs = 2'b00, e_is = 2'b00;
            logic [3:0] e_alu = 4'b0000;
            logic e_rw = 0, e_as = 0, e_m2r = 0, e_pcs = 0, e_mw = 0, e_pcw = 0, e_ir = 0, e_done = 0;
            bool_mem: begin end
            bus.ALUFlags = flag_in;
            bus.MemReady = ((cls == C_LDR || cls == C_STR) && k >= 3) ? (k >= 3 + w) : 1'($urandom);
            if (k == 0) e_ir = 1'b1;
            if (k == lat - 1) begin e_pcw = 1'b1; e_done = 1'b1; end
            case (cls)
                C_DP: begin
                    if (k == 2) begin e_state = imm ? 4'd7 : 4'd6; e_as = imm; e_alu = alu_of(cmd); end
                    if (k == 3) begin e_state = 4'd8; e_rw = writes; e_pcs = writes && (rd == 4'hF); end
                end
                C_BR: begin
                    if (k == 2) begin e_state = 4'd9; e_rs = 2'b01; e_is = 2'b10; e_as = 1'b1; e_pcs = 1'b1; end
                end
                C_LDR, C_STR: begin
                    if (k >= 2 && (k == 2 || (cls == C_LDR && k <= 3 + w))) begin
                        e_as = 1'b1; e_is = 2'b01; e_alu = up ? 4'b0000 : 4'b0001;
                        e_rs = (cls == C_STR) ? 2'b10 : 2'b00;
                    end
                    if (k >= 3) begin
                        if (cls == C_STR) begin e_state = 4'd5; e_mw = 1'b1; end
                        else if (k <= 3 + w) e_state = 4'd3;
                        else begin e_state = 4'd4; e_rw = 1'b1; e_m2r = 1'b1; e_pcs = (rd == 4'hF); end
                    end
                end
                default: ;
            endcase
            @(negedge clk);
            check($sformatf("%s c%0d state", name, k), 32'(bus.State), 32'(e_state));
            check($sformatf("%s c%0d ctl", name, k), 32'(observed_ctl()),
                  32'({e_rs, e_is, e_alu, e_rw, e_as, e_m2r, e_pcs, e_mw, e_pcw, e_ir, e_done}));
            @(posedge clk);
            #1;
        end
        if (cls == C_DP && loads) model_flags = flag_in;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset strobes", 32'({bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.InstrDone}), 32'(0));
        @(negedge clk);
        check("reset state", 32'(bus.State), 32'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        model_flags = 4'b0000;
    endtask

    initial begin
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;
        bus.MemReady = 1'b0;
        do_reset();

        // ADD R0,R1,#5
        flag_in = 4'b1011;
        run_instr("add", 32'hE2810005, 0);
        // CMP R0,#0 sets Z, then BEQ is taken
        flag_in = 4'b0100;
        run_instr("cmp", 32'hE3500000, 0);
        flag_in = 4'b0011;
        run_instr("beq", 32'h0A000002, 0);
        // BNE with Z set falls through in two cycles
        run_instr("bne", 32'h1A000002, 0);
        // LDR with three wait cycles, STR ready at once
        run_instr("ldr", 32'hE5901004, 3);
        run_instr("str", 32'hE5801004, 0);
        // Condition 1111 never executes
        run_instr("nv", 32'hF2810005, 0);

        // Reset in the middle of a read wait after flags were set
        flag_in = 4'b0100;
        run_instr("cmp2", 32'hE3500000, 0);
        bus.Instr    = 32'hE5901004;
        bus.MemReady = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("wait state", 32'(bus.State), 32'(3));
        reset = 1'b1;
        #1;
        check("wait reset strobes", 32'({bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.InstrDone}), 32'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        model_flags = 4'b0000;
        // Flags cleared, so BEQ must now fail
        run_instr("beq after rst", 32'h0A000002, 0);
        run_instr("mov pc", 32'hE1A0F001, 0);

        // Random instruction stream
        for (int i = 0; i < 250; i++) begin
            logic [31:0] ins  = $urandom;
            int          kind = $urandom_range(0, 9);
            int          w    = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            if (kind <= 4) begin
                ins[27:26] = 2'b00;
                if (!cmd_supported(ins[24:21])) ins[20] = 1'b0;
            end else if (kind <= 6) ins[27:26] = 2'b01;
            else if (kind <= 8)     ins[27:26] = 2'b10;
            else                    ins[27:26] = 2'b11;
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            flag_in = 4'($urandom);
            run_instr($sformatf("rnd%0d", i), ins, w);
        end

        @(negedge clk);
        check("final state", 32'(bus.State), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
